// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, opcode legality and controller FSM states shared by alu and alu_ctrl.
package alu_pkg;
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_NOT = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR};
   endfunction
endpackage

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: request, response and ALU operand channels of alu_ctrl.
interface alu_ctrl_if #(parameter int WIDTH = 32);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_out;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic             resp_zero;
   logic             resp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready, alu_out,
      input  req_ready, alu_a, alu_b, alu_op, resp_valid, resp_data, resp_zero, resp_err
   );
   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready, alu_out,
      output req_ready, alu_a, alu_b, alu_op, resp_valid, resp_data, resp_zero, resp_err
   );
endinterface

// File: rtl/lat_counter.sv
// lat_counter: loadable 4-bit down-counter that parks at zero and flags it.
module lat_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       en,
   input  logic [3:0] load_val,
   output logic       zero
);
   logic [3:0] cnt;

   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && !zero) cnt <= cnt - 4'd1;

   assign zero = cnt == 4'd0;
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: issues one request at a time to the ALU, waits ALU_LAT cycles
// and returns the captured result; illegal opcodes are answered locally.
module alu_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 0
) (
   input logic       clk,
   input logic       reset,
   alu_ctrl_if.slave bus
);
   state_t state;
   logic   accept;
   logic   legal;
   logic   lat_zero;

   // req_ready is high exactly in IDLE, so this also ignores req_valid elsewhere
   assign accept = bus.req_valid && bus.req_ready;
   assign legal  = is_legal_op(bus.req_op);

   lat_counter u_lat (
      .clk      (clk),
      .reset    (reset),
      .load     (accept && legal),
      .en       (state == EXEC),
      .load_val (4'(ALU_LAT)),
      .zero     (lat_zero)
   );

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state          <= IDLE;
         bus.req_ready  <= 1'b1;
         bus.alu_a      <= WIDTH'(0);
         bus.alu_b      <= WIDTH'(0);
         bus.alu_op     <= OP_ADD;
         bus.resp_valid <= 1'b0;
         bus.resp_data  <= WIDTH'(0);
         bus.resp_zero  <= 1'b0;
         bus.resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               bus.req_ready <= 1'b0;
               if (legal) begin
                  bus.alu_a  <= bus.req_a;
                  bus.alu_b  <= bus.req_b;
                  bus.alu_op <= bus.req_op;
                  state      <= EXEC;
               end else begin
                  bus.resp_data  <= WIDTH'(0);
                  bus.resp_zero  <= 1'b0;
                  bus.resp_err   <= 1'b1;
                  bus.resp_valid <= 1'b1;
                  state          <= RESP;
               end
            end
            EXEC: if (lat_zero) begin
               bus.resp_data  <= bus.alu_out;
               bus.resp_zero  <= bus.alu_out == WIDTH'(0);
               bus.resp_err   <= 1'b0;
               bus.resp_valid <= 1'b1;
               state          <= RESP;
            end
            RESP: if (bus.resp_ready) begin
               bus.resp_valid <= 1'b0;
               bus.req_ready  <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed scoreboard bench for alu_ctrl at ALU latencies 0, 3 and 5.
module tb_alu_ctrl;
   import alu_pkg::*;

   localparam int LATS [3] = '{0, 3, 5};

   typedef struct {
      logic [31:0] data;
      logic        zero;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid [3];
   logic        resp_ready [3];
   logic [3:0]  req_op [3];
   logic [31:0] req_a [3];
   logic [31:0] req_b [3];
   logic        req_ready_o [3];
   logic        resp_valid_o [3];
   logic        resp_zero_o [3];
   logic        resp_err_o [3];
   logic [31:0] resp_data_o [3];
   logic [31:0] alu_a_o [3];
   logic [31:0] alu_b_o [3];
   logic [3:0]  alu_op_o [3];

   logic [31:0] exp_a [3];
   logic [31:0] exp_b [3];
   logic [3:0]  exp_op [3];

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_MUL:  return a * b;
         OP_DIV:  return b == 0 ? 32'hFFFF_FFFF : a / b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NOT:  return ~a;
         OP_SHL:  return a << b[4:0];
         OP_SHR:  return a >> b[4:0];
         default: return 32'h0;
      endcase
   endfunction

   // Each DUT gets an ALU model whose output is junk until its inputs have been stable LAT cycles.
   for (genvar g = 0; g < 3; g++) begin : gd
      alu_ctrl_if #(.WIDTH(32)) bus ();
      logic [67:0] prev = '0;
      logic [3:0]  age = 4'd15;
      logic [67:0] cur;
      logic [3:0]  cur_age;
      assign cur     = {bus.alu_a, bus.alu_b, bus.alu_op};
      assign cur_age = cur != prev ? 4'd0 : age == 4'd15 ? age : age + 4'd1;
      always @(posedge clk) begin
         prev <= cur;
         age  <= cur_age;
      end
      assign bus.alu_out    = int'(cur_age) >= LATS[g] ? alu_f(bus.alu_op, bus.alu_a, bus.alu_b) : 32'hDEAD_BEEF;
      assign bus.req_valid  = req_valid[g];
      assign bus.req_op     = req_op[g];
      assign bus.req_a      = req_a[g];
      assign bus.req_b      = req_b[g];
      assign bus.resp_ready = resp_ready[g];
      assign req_ready_o[g]  = bus.req_ready;
      assign resp_valid_o[g] = bus.resp_valid;
      assign resp_zero_o[g]  = bus.resp_zero;
      assign resp_err_o[g]   = bus.resp_err;
      assign resp_data_o[g]  = bus.resp_data;
      assign alu_a_o[g]      = bus.alu_a;
      assign alu_b_o[g]      = bus.alu_b;
      assign alu_op_o[g]     = bus.alu_op;

      alu_ctrl #(.WIDTH(32), .ALU_LAT(LATS[g])) dut (
         .clk   (clk),
         .reset (rst_n),
         .bus   (bus.slave)
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_alu(input int k);
      chk("alu_a_stable", alu_a_o[k], exp_a[k]);
      chk("alu_b_stable", alu_b_o[k], exp_b[k]);
      chk("alu_op_stable", 32'(alu_op_o[k]), 32'(exp_op[k]));
   endtask

   task automatic issue(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic z, input logic e);
      exp_t x;
      chk("req_ready_at_accept", 32'(req_ready_o[k]), 32'd1);
      req_op[k]    = op;
      req_a[k]     = a;
      req_b[k]     = b;
      req_valid[k] = 1'b1;
      x.data = d;
      x.zero = z;
      x.err  = e;
      sb.push_back(x);
      if (op <= 4'd9) begin
         exp_a[k]  = a;
         exp_b[k]  = b;
         exp_op[k] = op;
      end
      tick();
      req_valid[k] = 1'b0;
   endtask

   // Called in the cycle after acceptance; lat counts cycles from the accept cycle.
   task automatic await(input int k, input int lat);
      int   n = 1;
      exp_t e;
      while (!resp_valid_o[k] && n < 40) begin
         chk_alu(k);
         tick();
         n++;
      end
      chk("resp_latency", 32'(n), 32'(lat));
      chk_alu(k);
      chk("scoreboard_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("resp_data", resp_data_o[k], e.data);
         chk("resp_zero", 32'(resp_zero_o[k]), 32'(e.zero));
         chk("resp_err", 32'(resp_err_o[k]), 32'(e.err));
      end
      chk("req_ready_low_in_resp", 32'(req_ready_o[k]), 32'd0);
      if (resp_ready[k]) begin
         tick();
         chk("resp_valid_after_hs", 32'(resp_valid_o[k]), 32'd0);
         chk("req_ready_after_hs", 32'(req_ready_o[k]), 32'd1);
      end
   endtask

   initial begin
      int hits;
      for (int k = 0; k < 3; k++) begin
         req_valid[k]  = 1'b0;
         resp_ready[k] = 1'b1;
         req_op[k]     = 4'd0;
         req_a[k]      = 32'd0;
         req_b[k]      = 32'd0;
         exp_a[k]      = 32'd0;
         exp_b[k]      = 32'd0;
         exp_op[k]     = 4'd0;
      end
      repeat (2) tick();
      chk("resp_valid_in_reset", 32'(resp_valid_o[0]), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_req_ready", 32'(req_ready_o[0]), 32'd1);
      chk("rst_alu_a", alu_a_o[0], 32'd0);
      chk("rst_alu_b", alu_b_o[0], 32'd0);
      chk("rst_alu_op", 32'(alu_op_o[0]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid_o[0]), 32'd0);
      chk("rst_resp_data", resp_data_o[0], 32'd0);
      chk("rst_resp_zero", 32'(resp_zero_o[0]), 32'd0);
      chk("rst_resp_err", 32'(resp_err_o[0]), 32'd0);

      issue(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
      await(0, 2);

      issue(1, OP_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
      await(1, 5);

      issue(1, 4'b1100, 32'h1234, 32'h5678, 32'd0, 1'b0, 1'b1);
      await(1, 1);
      chk("illegal_keeps_alu_op", 32'(alu_op_o[1]), 32'(OP_SUB));

      resp_ready[1] = 1'b0;
      issue(1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
      await(1, 5);
      req_op[1]    = OP_OR;
      req_a[1]     = 32'h1;
      req_b[1]     = 32'h2;
      req_valid[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_resp_valid", 32'(resp_valid_o[1]), 32'd1);
         chk("bp_resp_data", resp_data_o[1], 32'h0000_F000);
         chk("bp_resp_zero", 32'(resp_zero_o[1]), 32'd0);
         chk("bp_resp_err", 32'(resp_err_o[1]), 32'd0);
         chk("bp_req_ready", 32'(req_ready_o[1]), 32'd0);
         chk_alu(1);
      end
      req_valid[1]  = 1'b0;
      resp_ready[1] = 1'b1;
      tick();
      chk("bp_req_ready_after_hs", 32'(req_ready_o[1]), 32'd1);
      chk("bp_resp_valid_after_hs", 32'(resp_valid_o[1]), 32'd0);
      chk("bp_request_not_taken", 32'(alu_op_o[1]), 32'(OP_AND));

      issue(2, OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_alu_a", alu_a_o[2], 32'd0);
      chk("midrst_alu_b", alu_b_o[2], 32'd0);
      chk("midrst_req_ready", 32'(req_ready_o[2]), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid_o[2]), 32'd0);
      chk("midrst_resp_data", resp_data_o[2], 32'd0);
      sb.delete();
      for (int k = 0; k < 3; k++) begin
         exp_a[k]  = 32'd0;
         exp_b[k]  = 32'd0;
         exp_op[k] = 4'd0;
      end
      tick();
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (resp_valid_o[2]) hits++;
      end
      chk("midrst_no_response", 32'(hits), 32'd0);
      issue(2, OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
      await(2, 7);

      issue(0, OP_XOR, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      req_op[0]    = OP_SHL;
      req_a[0]     = 32'h0000_0001;
      req_b[0]     = 32'd4;
      req_valid[0] = 1'b1;
      begin
         exp_t x;
         x.data = 32'h0000_0010;
         x.zero = 1'b0;
         x.err  = 1'b0;
         sb.push_back(x);
      end
      await(0, 2);
      exp_a[0]  = 32'h0000_0001;
      exp_b[0]  = 32'd4;
      exp_op[0] = OP_SHL;
      tick();
      req_valid[0] = 1'b0;
      await(0, 2);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Initiator for the ALU operand interface: accepts one operation request at a time over a valid/ready channel and drives the ALU `a`/`b`/`op` inputs, holding them stable. It waits a fixed ALU latency, captures the ALU `out`, and returns the result with status flags over a valid/ready response channel. It sits between the instruction/command source and `alu`. Illegal opcodes are rejected locally and never reach the ALU.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must match the ALU.
- `ALU_LAT`, 0: cycles from stable ALU inputs to valid `out`; legal range 0–15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; all state clears while low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_op`  in  4  opcode.
- `req_a`  in  WIDTH  operand A.
- `req_b`  in  WIDTH  operand B.
- `alu_a`  out  WIDTH  to ALU `a`, registered.
- `alu_b`  out  WIDTH  to ALU `b`, registered.
- `alu_op`  out  4  to ALU `op`, registered.
- `alu_out`  in  WIDTH  from ALU `out`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_data`  out  WIDTH  result, 0 on error.
- `resp_zero`  out  1  result == 0, valid with `resp_valid`.
- `resp_err`  out  1  opcode illegal (4'b1010–4'b1111).

## Operation
- Legal opcodes: ADD 0000, SUB 0001, MUL 0010, DIV 0011, AND 0100, OR 0101, XOR 0110, NOT 0111, SHL 1000, SHR 1001.
- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`:
  - Legal op: load `alu_a`/`alu_b`/`alu_op` from the request, load the latency counter with `ALU_LAT`, go to EXEC.
  - Illegal op: leave the ALU registers unchanged, set `resp_data`=0, `resp_err`=1, `resp_zero`=0, go to RESP.
- EXEC: `req_ready`=0.
  - Counter nonzero: decrement.
  - Counter zero: capture `alu_out` into `resp_data`, set `resp_zero`=(`alu_out`==0) and `resp_err`=0, go to RESP.
- RESP: `resp_valid`=1. All `resp_*` outputs are held stable until `resp_valid && resp_ready`, then go to IDLE.
- `alu_*` outputs hold their last values in every state; they change only on acceptance of a legal request.
- No arithmetic is done here; the result is `alu_out` passed through at WIDTH bits, untruncated.

## Timing
- Reset values: state IDLE, `req_ready`=1 once `reset` deasserts, `alu_a`=0, `alu_b`=0, `alu_op`=0000, `resp_valid`=0, `resp_data`=0, `resp_zero`=0, `resp_err`=0, counter 0.
- Legal op accepted in cycle N:
  - `alu_*` valid from cycle N+1.
  - Capture at the end of cycle N+1+`ALU_LAT`.
  - `resp_valid` high from cycle N+2+`ALU_LAT`.
- Illegal op accepted in cycle N: `resp_valid` high from cycle N+1.
- Response handshake in cycle M: `req_ready` high from cycle M+1. No overlap of request and response; maximum throughput is one op per 3+`ALU_LAT` cycles.
- `resp_ready` held high while waiting: the response completes in its first valid cycle.
- `req_valid` is ignored outside IDLE; the request fields are sampled only at the handshake.
- Reset asserted mid-operation: the outstanding request is dropped, no response is produced, and all outputs return to their reset values immediately.

## Structure
- Opcode localparams go into a shared package, `alu_pkg`, used by both `alu` and `alu_ctrl`. `alu_pkg` also holds an `is_legal_op` function and the FSM state enum.
- One sub-module is natural: `lat_counter` (loadable down-counter, 4 bits, zero flag).
- Everything else stays flat.

## Test plan
- ADD, `ALU_LAT`=0, a=5, b=7, ALU model returns 12 → `resp_valid` 2 cycles after accept; `resp_data`=12, `resp_zero`=0, `resp_err`=0.
- SUB, `ALU_LAT`=3, a=9, b=9, model returns 0 → `resp_valid` exactly 5 cycles after accept; `resp_zero`=1; `alu_a`/`alu_b`/`alu_op` stable throughout.
- `req_op`=4'b1100 → `resp_valid` next cycle, `resp_err`=1, `resp_data`=0; `alu_op` keeps its previous value.
- Backpressure: `resp_ready`=0 for 4 cycles → all `resp_*` stable, `req_ready`=0, a new `req_valid` is not accepted; `req_ready` rises the cycle after the handshake.
- `reset` pulsed low during EXEC (`ALU_LAT`=5) → no response; outputs return to reset values; the next request completes normally.
- Back-to-back requests XOR 0xFFFF0000^0x0000FFFF then SHL → results returned in order, each with `resp_zero`=0.
